// File: rtl/divider_taint_track_word.sv
// Constant-time restoring unsigned divider with word-level taint tracking.
// One restoring step per cycle; WIDTH steps for every operand value.
module divider_taint_track_word #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic             dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic             divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic             quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic             remainder_t,
  output logic             quotientDone,
  output logic             quotientDone_t
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;
  logic             dtaint;
  logic             ctaint;
  logic             done;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;
  logic             last;

  assign last = (cnt == LAST);

  // Both candidates are always formed; only the mux select depends on data.
  always_comb begin
    rs     = {r, q[WIDTH-1]};
    diff   = rs - {1'b0, d};
    q_step = {q[WIDTH-2:0], ~diff[WIDTH]};
    r_step = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = ITER;
      ITER: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      q      <= '0;
      d      <= '0;
      r      <= '0;
      cnt    <= '0;
      dtaint <= 1'b0;
      ctaint <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == ITER) && last;
      unique case (state)
        LOAD: begin
          q      <= dividend;
          d      <= divisor;
          r      <= '0;
          cnt    <= '0;
          dtaint <= dividend_t | divisor_t;
          ctaint <= start_t;
        end
        ITER: begin
          q   <= q_step;
          r   <= r_step;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient       = q;
  assign remainder      = r;
  assign quotientDone   = done;
  assign quotient_t     = dtaint | ctaint;
  assign remainder_t    = dtaint | ctaint;
  // Completion timing depends only on start, never on operand values.
  assign quotientDone_t = ctaint;

endmodule

// File: tb/tb_divider_taint_track_word.sv
// Directed bench for divider_taint_track_word at WIDTH=8.
// Done latency is counted in edges after the edge that samples start.
module tb_divider_taint_track_word;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         start_t;
  logic [W-1:0] dividend;
  logic         dividend_t;
  logic [W-1:0] divisor;
  logic         divisor_t;
  logic [W-1:0] quotient;
  logic         quotient_t;
  logic [W-1:0] remainder;
  logic         remainder_t;
  logic         quotientDone;
  logic         quotientDone_t;

  int passed;
  int total;

  divider_taint_track_word #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_t       (start_t),
    .dividend      (dividend),
    .dividend_t    (dividend_t),
    .divisor       (divisor),
    .divisor_t     (divisor_t),
    .quotient      (quotient),
    .quotient_t    (quotient_t),
    .remainder     (remainder),
    .remainder_t   (remainder_t),
    .quotientDone  (quotientDone),
    .quotientDone_t(quotientDone_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation from IDLE and returns at the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic at, input logic bt, input logic st,
                        output int lat);
    @(posedge clk); #1;
    dividend   = a;
    divisor    = b;
    dividend_t = at;
    divisor_t  = bt;
    start_t    = st;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (quotientDone) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0; start_t = 1'b0;
    dividend = '0; divisor = '0;
    dividend_t = 1'b0; divisor_t = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({quotient, remainder} !== 16'h0) $display("FAIL reset_data: got %h expected 0000", {quotient, remainder});
    else passed++;
    total++;
    if ({quotient_t, remainder_t, quotientDone, quotientDone_t} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {quotient_t, remainder_t, quotientDone, quotientDone_t});
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(8'd100, 8'd7, 1'b0, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 9) $display("FAIL basic_latency: got %0d expected 9", lat);
    else passed++;
    total++;
    if (quotient !== 8'd14) $display("FAIL basic_quotient: got %0d expected 14", quotient);
    else passed++;
    total++;
    if (remainder !== 8'd2) $display("FAIL basic_remainder: got %0d expected 2", remainder);
    else passed++;
    total++;
    if ({quotient_t, remainder_t, quotientDone_t} !== 3'b000)
      $display("FAIL basic_taint: got %b expected 000", {quotient_t, remainder_t, quotientDone_t});
    else passed++;
    @(posedge clk); #1;
    total++;
    if (quotientDone !== 1'b0) $display("FAIL basic_pulse_width: got %b expected 0", quotientDone);
    else passed++;
    total++;
    if ({quotient, remainder} !== {8'd14, 8'd2})
      $display("FAIL basic_hold: got %0d/%0d expected 14/2", quotient, remainder);
    else passed++;
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(8'd255, 8'd0, 1'b0, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 9) $display("FAIL divzero_latency: got %0d expected 9", lat);
    else passed++;
    total++;
    if ({quotient, remainder} !== {8'd255, 8'd255})
      $display("FAIL divzero_result: got %0d/%0d expected 255/255", quotient, remainder);
    else passed++;
    run_op(8'd37, 8'd0, 1'b0, 1'b0, 1'b0, lat);
    total++;
    if ({quotient, remainder} !== {8'd255, 8'd37})
      $display("FAIL divzero_rem_dividend: got %0d/%0d expected 255/37", quotient, remainder);
    else passed++;
  endtask

  task automatic test_small_large();
    int lat_a;
    int lat_b;
    run_op(8'd5, 8'd9, 1'b0, 1'b0, 1'b0, lat_a);
    total++;
    if ({quotient, remainder} !== {8'd0, 8'd5})
      $display("FAIL small_result: got %0d/%0d expected 0/5", quotient, remainder);
    else passed++;
    run_op(8'd200, 8'd1, 1'b0, 1'b0, 1'b0, lat_b);
    total++;
    if ({quotient, remainder} !== {8'd200, 8'd0})
      $display("FAIL large_result: got %0d/%0d expected 200/0", quotient, remainder);
    else passed++;
    total++;
    if (lat_a !== 9 || lat_b !== 9)
      $display("FAIL const_time: got %0d,%0d expected 9,9", lat_a, lat_b);
    else passed++;
  endtask

  task automatic test_taint();
    int lat;
    run_op(8'd100, 8'd7, 1'b1, 1'b0, 1'b0, lat);
    total++;
    if ({quotient_t, remainder_t, quotientDone_t} !== 3'b110)
      $display("FAIL taint_data: got %b expected 110", {quotient_t, remainder_t, quotientDone_t});
    else passed++;
    run_op(8'd60, 8'd6, 1'b0, 1'b0, 1'b1, lat);
    total++;
    if ({quotient_t, remainder_t, quotientDone_t} !== 3'b111)
      $display("FAIL taint_ctrl: got %b expected 111", {quotient_t, remainder_t, quotientDone_t});
    else passed++;
    total++;
    if ({quotient, remainder} !== {8'd10, 8'd0})
      $display("FAIL taint_ctrl_result: got %0d/%0d expected 10/0", quotient, remainder);
    else passed++;
    run_op(8'd9, 8'd4, 1'b0, 1'b1, 1'b0, lat);
    total++;
    if ({quotient_t, remainder_t, quotientDone_t} !== 3'b110)
      $display("FAIL taint_divisor: got %b expected 110", {quotient_t, remainder_t, quotientDone_t});
    else passed++;
  endtask

  task automatic test_restart_ignored();
    int first;
    int pulses;
    @(posedge clk); #1;
    dividend = 8'd100; divisor = 8'd7;
    dividend_t = 1'b0; divisor_t = 1'b0; start_t = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first = -1;
    pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (quotientDone) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (first == k) begin
        total++;
        if ({quotient, remainder} !== {8'd14, 8'd2})
          $display("FAIL restart_result: got %0d/%0d expected 14/2", quotient, remainder);
        else passed++;
      end
      if (k == 4) begin
        start = 1'b1;
        dividend = 8'd50;
      end
      if (k == 5) start = 1'b0;
    end
    total++;
    if (first !== 9) $display("FAIL restart_latency: got %0d expected 9", first);
    else passed++;
    total++;
    if (pulses !== 1) $display("FAIL restart_pulses: got %0d expected 1", pulses);
    else passed++;
  endtask

  task automatic test_async_reset();
    int pulses;
    int lat;
    @(posedge clk); #1;
    dividend = 8'd100; divisor = 8'd7;
    dividend_t = 1'b1; divisor_t = 1'b0; start_t = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({quotient_t, remainder_t, quotientDone_t} !== 3'b111)
      $display("FAIL arst_pre_taint: got %b expected 111", {quotient_t, remainder_t, quotientDone_t});
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({quotient, remainder} !== 16'h0)
      $display("FAIL arst_data: got %h expected 0000", {quotient, remainder});
    else passed++;
    total++;
    if ({quotient_t, remainder_t, quotientDone, quotientDone_t} !== 4'b0)
      $display("FAIL arst_flags: got %b expected 0000", {quotient_t, remainder_t, quotientDone, quotientDone_t});
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (quotientDone) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL arst_no_done: got %0d expected 0", pulses);
    else passed++;
    run_op(8'd100, 8'd7, 1'b0, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 9 || {quotient, remainder} !== {8'd14, 8'd2})
      $display("FAIL arst_recover: got lat %0d %0d/%0d expected lat 9 14/2", lat, quotient, remainder);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int at[3];
    int n;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dividend = 8'd77; divisor = 8'd10;
    dividend_t = 1'b0; divisor_t = 1'b0; start_t = 1'b0;
    start = 1'b1;
    n = 0;
    at[0] = -1; at[1] = -1; at[2] = -1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (quotientDone && n < 3) begin
        at[n] = k;
        n++;
      end
      if (k == 22) start = 1'b0;
    end
    total++;
    if (at[0] !== 9 || at[1] !== 20 || at[2] !== 31)
      $display("FAIL b2b_spacing: got %0d,%0d,%0d expected 9,20,31", at[0], at[1], at[2]);
    else passed++;
    total++;
    if ({quotient, remainder} !== {8'd7, 8'd7})
      $display("FAIL b2b_result: got %0d/%0d expected 7/7", quotient, remainder);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_small_large();
    test_taint();
    test_restart_ignored();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
